// File: rtl/btn_reset_conditioner.sv
// -----------------------------------------------------------------------------
// btn_reset_conditioner
//
// Conditions the pet's physical reset push-button. The raw pin is synchronised,
// debounced and interpreted. The block produces a press event, a long-press
// ("restart pet") event, and a fixed-length buzzer gate for the tone generator.
//
// Optional feature (compile-time macro LONG_PRESS_BEEP_EN):
//   When defined, a long_press also reloads the beep timer with 2*BEEP_CYCLES.
//   When undefined, only press_pulse loads the beep timer.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles the synchronised input must disagree with btn_clean
//                    before btn_clean follows it
//   HOLD_CYCLES      cycles after press_pulse until long_press fires
//   BEEP_CYCLES      beep_en duration per press
//   ACTIVE_LOW       1: btn_raw reads 0 when pressed; 0: reads 1 when pressed
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_raw      in   raw button pin, asynchronous to clk
//   btn_clean    out  debounced level, 1 = pressed
//   press_pulse  out  one-cycle pulse per debounced press
//   long_press   out  one-cycle pulse, at most once per press
//   beep_en      out  buzzer gate for the tone generator
// -----------------------------------------------------------------------------
module btn_reset_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 250_000_000,
    parameter int BEEP_CYCLES     = 10_000_000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_clean,
    output logic press_pulse,
    output logic long_press,
    output logic beep_en
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
`ifdef LONG_PRESS_BEEP_EN
    localparam int BW = $clog2(2 * BEEP_CYCLES + 1);
`else
    localparam int BW = $clog2(BEEP_CYCLES + 1);
`endif

    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_CYCLES);
`ifdef LONG_PRESS_BEEP_EN
    localparam logic [BW-1:0] BEEP_LONG = BW'(2 * BEEP_CYCLES);
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        WAIT_RELEASE
    } state_t;

    // Normalise so that 1 always means "pressed" from here on.
    logic btn_pressed;
    assign btn_pressed = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // Two-flop synchroniser; resets to the released level (0 after
    // normalisation). As a result, a button held through reset must be
    // debounced again as a fresh press.
    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], btn_pressed};
        end
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive disagreeing cycles. The counter is
    // allowed to sit at DEB_MAX for one cycle, and the toggle happens on
    // the following disagreeing cycle. The counter therefore tops out at
    // DEB_MAX and cannot wrap.
    // ------------------------------------------------------------------
    logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
    logic          clean_reg, clean_next;

    always_comb begin
        deb_cnt_next = '0;
        clean_next   = clean_reg;
        if (sync_reg[1] != clean_reg) begin
            if (deb_cnt_reg == DEB_MAX) begin
                clean_next = ~clean_reg;
            end else begin
                deb_cnt_next = deb_cnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hold FSM. It only looks at the registered clean level. Being in IDLE
    // with clean_reg high therefore always means a fresh rising edge: every
    // path back to IDLE requires clean_reg low.
    // ------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic          press_next, long_next;

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        press_next    = 1'b0;
        long_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clean_reg) begin
                    state_next    = PRESSED;
                    press_next    = 1'b1;
                    hold_cnt_next = '0;
                end
            end
            PRESSED: begin
                // A release takes priority over the hold count completing.
                if (!clean_reg) begin
                    state_next = IDLE;
                end else begin
                    if (hold_cnt_reg != HOLD_MAX) begin
                        hold_cnt_next = hold_cnt_reg + 1'b1;
                    end
                    if (hold_cnt_reg == HOLD_LAST) begin
                        long_next  = 1'b1;
                        state_next = WAIT_RELEASE;
                    end
                end
            end
            WAIT_RELEASE: begin
                if (!clean_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Beep down-counter. Loads happen in the same cycle as the pulse that
    // causes them. As a result, beep_en rises together with press_pulse,
    // and a reload while counting leaves no gap.
    // ------------------------------------------------------------------
    logic [BW-1:0] beep_cnt_reg, beep_cnt_next;

    always_comb begin
        beep_cnt_next = beep_cnt_reg;
        if (press_next) begin
            beep_cnt_next = BEEP_LOAD;
        end
`ifdef LONG_PRESS_BEEP_EN
        else if (long_next) begin
            beep_cnt_next = BEEP_LONG;
        end
`endif
        else if (beep_cnt_reg != '0) begin
            beep_cnt_next = beep_cnt_reg - 1'b1;
        end
    end

    logic press_reg, long_reg, beep_en_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_reg  <= '0;
            clean_reg    <= 1'b0;
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            press_reg    <= 1'b0;
            long_reg     <= 1'b0;
            beep_cnt_reg <= '0;
            beep_en_reg  <= 1'b0;
        end else begin
            deb_cnt_reg  <= deb_cnt_next;
            clean_reg    <= clean_next;
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            press_reg    <= press_next;
            long_reg     <= long_next;
            beep_cnt_reg <= beep_cnt_next;
            beep_en_reg  <= (beep_cnt_next != '0);
        end
    end

    assign btn_clean   = clean_reg;
    assign press_pulse = press_reg;
    assign long_press  = long_reg;
    assign beep_en     = beep_en_reg;

endmodule

// File: tb/tb_btn_reset_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for btn_reset_conditioner.
//
// Main DUT: DEBOUNCE=4, HOLD=20, BEEP=6, ACTIVE_LOW=1.
// A second instance with a longer beep (16) lets the retrigger case land a
// second press_pulse while beep_en is still high. With DEBOUNCE=4 and BEEP=6
// this cannot happen, because two rises are at least 10 cycles apart.
//
// Cycle numbering: cycle 0 is the first clock edge that samples the new
// btn_raw level. Outputs are sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_btn_reset_conditioner;

    localparam int D  = 4;
    localparam int H  = 20;
    localparam int B  = 6;
    localparam int B2 = 16;

`ifdef LONG_PRESS_BEEP_EN
    localparam int LB_LO = 27;
    localparam int LB_HI = 38;
`else
    localparam int LB_LO = -1;
    localparam int LB_HI = -1;
`endif

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic btn_raw  = 1'b1;
    logic btn_raw2 = 1'b1;
    logic clean, press, lng, beep;
    logic clean2, press2, lng2, beep2;

    always #5 clk = ~clk;

    btn_reset_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .BEEP_CYCLES(B), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_clean(clean), .press_pulse(press), .long_press(lng), .beep_en(beep)
    );

    btn_reset_conditioner #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .BEEP_CYCLES(B2), .ACTIVE_LOW(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw2),
        .btn_clean(clean2), .press_pulse(press2), .long_press(lng2), .beep_en(beep2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int cyc, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (lo >= 0) && (c >= lo) && (c <= hi);
    endfunction

    // One press of length hold_len cycles followed by release. Event cycles
    // are hand-computed; -1 means "never".
    typedef struct {
        int hold_len;
        int run_len;
        int rise;
        int fall;
        int press;
        int lng;
        int b1_lo;
        int b1_hi;
        int b2_lo;
        int b2_hi;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // clean press, 12 cycles
        vecs[0] = '{12, 30, 6, 18, 7, -1, 7, 12, -1, -1};
        // 4-cycle press: one short of passing debounce
        vecs[1] = '{4, 15, -1, -1, -1, -1, -1, -1, -1, -1};
        // 5-cycle press: shortest press that passes debounce
        vecs[2] = '{5, 20, 6, 11, 7, -1, 7, 12, -1, -1};
        // long hold, 40 cycles
        vecs[3] = '{40, 55, 6, 46, 7, 27, 7, 12, LB_LO, LB_HI};
        // release seen in the cycle the hold count completes: release wins
        vecs[4] = '{20, 35, 6, 26, 7, -1, 7, 12, -1, -1};
        // release one cycle later: long_press still fires
        vecs[5] = '{21, 45, 6, 27, 7, 27, 7, 12, LB_LO, LB_HI};

        // ---------------- reset state ----------------
        step();
        step();
        chk("reset.clean", 0, clean, 1'b0);
        chk("reset.press", 0, press, 1'b0);
        chk("reset.long",  0, lng,   1'b0);
        chk("reset.beep",  0, beep,  1'b0);
        chk("reset.beep2", 0, beep2, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // ---------------- table-driven presses ----------------
        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < vecs[v].run_len; c++) begin
                btn_raw = (c < vecs[v].hold_len) ? 1'b0 : 1'b1;
                step();
                chk($sformatf("vec%0d.clean", v), c, clean,
                    (vecs[v].rise >= 0) && (c >= vecs[v].rise) && (c < vecs[v].fall));
                chk($sformatf("vec%0d.press", v), c, press, c == vecs[v].press);
                chk($sformatf("vec%0d.long", v),  c, lng,   c == vecs[v].lng);
                chk($sformatf("vec%0d.beep", v),  c, beep,
                    in_rng(c, vecs[v].b1_lo, vecs[v].b1_hi) ||
                    in_rng(c, vecs[v].b2_lo, vecs[v].b2_hi));
            end
            $display("vec%0d hold=%0d cycles done, errors so far %0d", v, vecs[v].hold_len, errors);
        end

        // ---------------- bounce rejection ----------------
        for (int c = 0; c < 30; c++) begin
            btn_raw = (c < 20) ? (((c / 2) % 2) != 0) : 1'b1;
            step();
            chk("bounce.clean", c, clean, 1'b0);
            chk("bounce.press", c, press, 1'b0);
            chk("bounce.long",  c, lng,   1'b0);
            chk("bounce.beep",  c, beep,  1'b0);
        end
        $display("bounce sequence done, errors so far %0d", errors);

        // ---------------- retrigger (long-beep instance) ----------------
        for (int c = 0; c < 40; c++) begin
            btn_raw2 = ((c <= 4) || (c >= 10 && c <= 14)) ? 1'b0 : 1'b1;
            step();
            chk("retrig.clean", c, clean2, in_rng(c, 6, 10) || in_rng(c, 16, 20));
            chk("retrig.press", c, press2, (c == 7) || (c == 17));
            chk("retrig.long",  c, lng2,   1'b0);
            chk("retrig.beep",  c, beep2,  in_rng(c, 7, 32));
        end
        $display("retrigger sequence done, errors so far %0d", errors);

        // ---------------- reset mid-beep with button held ----------------
        for (int c = 0; c < 9; c++) begin
            btn_raw = 1'b0;
            step();
        end
        chk("midrst.beep_before", 8, beep, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst.clean", 0, clean, 1'b0);
        chk("midrst.press", 0, press, 1'b0);
        chk("midrst.long",  0, lng,   1'b0);
        chk("midrst.beep",  0, beep,  1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("midrst.hold_beep",  c, beep,  1'b0);
            chk("midrst.hold_clean", c, clean, 1'b0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            chk("postrst.clean", c, clean, c >= 6);
            chk("postrst.press", c, press, c == 7);
            chk("postrst.beep",  c, beep,  in_rng(c, 7, 12));
            chk("postrst.long",  c, lng,   1'b0);
        end
        btn_raw = 1'b1;
        for (int c = 0; c < 10; c++) step();
        chk("final.clean", 0, clean, 1'b0);
        $display("reset sequence done, errors so far %0d", errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_reset_conditioner.md
# btn_reset_conditioner

Input conditioner for the pet's physical reset button, placed directly upstream of the reset-button tone generator. It synchronises and debounces the raw push-button and produces three outputs:
- a one-cycle press event;
- a one-cycle long-press event, which the game FSM uses as its "restart pet" command;
- a timed `beep_en` gate, which drives the tone generator's `btn_reset` input so the buzzer sounds for a fixed duration rather than for as long as the button is held.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000 — cycles the synchronised input must differ continuously from `btn_clean` before `btn_clean` updates (20 ms at 50 MHz).
- `HOLD_CYCLES`, 250_000_000 — cycles `btn_clean` must stay high before `long_press` fires (5 s).
- `BEEP_CYCLES`, 10_000_000 — `beep_en` duration per press (200 ms).
- `ACTIVE_LOW`, 1 — 1: `btn_raw` is 0 when pressed; 0: `btn_raw` is 1 when pressed.

Ports:
- `clk` in 1 — system clock, 50 MHz.
- `rst_n` in 1 — asynchronous, active-low reset.
- `btn_raw` in 1 — raw board button, asynchronous to `clk`.
- `btn_clean` out 1 — debounced level, 1 = pressed.
- `press_pulse` out 1 — one-cycle pulse per debounced press.
- `long_press` out 1 — one-cycle pulse, at most once per press.
- `beep_en` out 1 — buzzer gate to the tone generator.

## Operation
- Polarity: `btn_raw` is normalised to pressed = 1 via `ACTIVE_LOW`.
- Synchroniser: two flip-flops. Both reset to the "released" level.
- Debounce counter:
  - Increments each cycle that the synchronised value ≠ `btn_clean`.
  - Clears in any cycle where they are equal.
  - On reaching `DEBOUNCE_CYCLES`, `btn_clean` toggles and the counter clears.
  - Counter width: `$clog2(DEBOUNCE_CYCLES+1)`. It must never wrap.
- Hold FSM, states `IDLE`, `PRESSED`, `WAIT_RELEASE`:
  - `IDLE` → `PRESSED` on a `btn_clean` rising edge. `press_pulse` = 1 for that cycle; hold counter cleared.
  - `PRESSED`: hold counter increments while `btn_clean` = 1.
    - When the count reaches `HOLD_CYCLES`: `long_press` = 1 for one cycle, then → `WAIT_RELEASE`.
    - `btn_clean` falling before that: → `IDLE`, no `long_press`.
  - `WAIT_RELEASE` → `IDLE` on `btn_clean` = 0. No further pulses while in this state.
  - Hold counter width: `$clog2(HOLD_CYCLES+1)`. It saturates and never wraps.
- Beep timer (down-counter):
  - On `press_pulse`, loads `BEEP_CYCLES`.
  - `beep_en` = (counter ≠ 0). The counter decrements to 0 and stops there.
  - A release does not shorten the beep.
  - A new `press_pulse` while counting reloads the counter; `beep_en` stays high with no gap.
- Reset (asserted at any time, including mid-press or mid-beep):
  - All counters 0; FSM `IDLE`.
  - `btn_clean`, `press_pulse`, `long_press`, `beep_en` all 0.
  - After deassertion, a button still held is treated as a new press and must pass the full debounce first.

## Timing
- All outputs are registered. Reset values of all outputs are 0.
- `btn_clean` rises `DEBOUNCE_CYCLES + 2` cycles after the first `clk` edge that samples a stable pressed level (2 synchroniser cycles + debounce count).
- `press_pulse` and `beep_en` rise one cycle after `btn_clean` rises, in the same cycle as each other.
- `beep_en` stays high for exactly `BEEP_CYCLES` cycles.
- `long_press` occurs `HOLD_CYCLES` cycles after `press_pulse`, provided `btn_clean` stays 1 throughout.
- Bounce: any glitch or bounce shorter than `DEBOUNCE_CYCLES` consecutive cycles produces no change on any output.
- Simultaneous `btn_clean` fall and hold-count reaching `HOLD_CYCLES`: the release wins. No `long_press` is issued; FSM → `IDLE`.

## Configuration
- `LONG_PRESS_BEEP_EN` defined:
  - A `long_press` pulse also reloads the beep timer with `2*BEEP_CYCLES`.
  - Timer width grows to `$clog2(2*BEEP_CYCLES+1)`.
  - If a beep is still active, `beep_en` stays high continuously through the reload.
- Not defined:
  - Only `press_pulse` loads the timer. `long_press` has no effect on `beep_en`.

## Test plan
Parameters for the bench: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=20, `BEEP_CYCLES`=6, `ACTIVE_LOW`=1.
- Clean press: `btn_raw` 1→0, held for 12 cycles, then released → `btn_clean` = 1 at cycle 6; `press_pulse` one cycle at cycle 7; `beep_en` high for cycles 7–12; no `long_press`.
- Bounce rejection: `btn_raw` toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 → all outputs remain 0.
- Long hold: press held for 40 cycles → `press_pulse` at cycle 7; `long_press` exactly once, at cycle 27; no second pulse before release. With `LONG_PRESS_BEEP_EN` defined, `beep_en` is also high for cycles 27–38.
- Release at the hold boundary: `btn_clean` falls in the same cycle the hold count reaches 20 → no `long_press`; FSM returns to `IDLE`.
- Retrigger: a second debounced press whose `press_pulse` lands while `beep_en` is still high → `beep_en` stays high with no gap and lasts 6 cycles from the second `press_pulse`.
- Reset mid-operation: `rst_n` = 0 during `beep_en` while the button is held; release `rst_n` with the button still held → outputs 0 immediately; `press_pulse` re-fires 7 cycles after `rst_n` deassertion.
